// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: raster sequencer for the VGA pipeline.
// Divides clk down to the pixel rate, walks counter_x/counter_y over the full
// raster, and emits video_on/hsync/vsync delayed by PIPE_DELAY clk so they line
// up with the draw blocks. Also provides line/frame strobes and a frame counter.
module vga_timing_ctrl #(
    parameter int   CLK_DIV    = 4,
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [9:0] counter_x,
    output logic [9:0] counter_y,
    output logic       pix_tick,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Parameter sanity: counters are 10 bits, divider 4 bits, delay line up to 7 deep.
    if (H_TOTAL > 1024) begin : g_bad_htotal
        $error("vga_timing_ctrl: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_vtotal
        $error("vga_timing_ctrl: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_ctrl: CLK_DIV must be 1..16");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe
        $error("vga_timing_ctrl: PIPE_DELAY must be 0..7");
    end

    logic [3:0] div_cnt_q, div_cnt_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] fc_q, fc_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    logic       vis_raw, hs_raw, vs_raw;
    logic       hsync_raw, vsync_raw;

    // The raster advances on the last divider phase of an enabled cycle.
    assign pix_tick = enable && (div_cnt_q == DIV_LAST);

    // Next-state for divider, raster counters, strobes and frame counter.
    always_comb begin
        div_cnt_d = div_cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        fc_d      = fc_q;
        ls_d      = 1'b0;
        fs_d      = 1'b0;
        if (enable) begin
            div_cnt_d = pix_tick ? 4'd0 : div_cnt_q + 4'd1;
        end
        if (pix_tick) begin
            if (x_q == H_LAST) begin
                x_d  = 10'd0;
                ls_d = 1'b1;
                if (y_q == V_LAST) begin
                    y_d  = 10'd0;
                    fs_d = 1'b1;
                    fc_d = fc_q + 8'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Raster state register; reset parks the raster at (0,0) with no strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= 4'd0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            fc_q      <= 8'd0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fc_q      <= fc_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
        end
    end

    assign counter_x   = x_q;
    assign counter_y   = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

    // Undelayed raster decode from the registered counters.
    assign vis_raw   = (x_q < H_ACT) && (y_q < V_ACT);
    assign hs_raw    = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    assign vs_raw    = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    assign hsync_raw = hs_raw ? SYNC_POL : ~SYNC_POL;
    assign vsync_raw = vs_raw ? SYNC_POL : ~SYNC_POL;

    if (PIPE_DELAY == 0) begin : g_nodly
        assign video_on = vis_raw;
        assign hsync    = hsync_raw;
        assign vsync    = vsync_raw;
    end else begin : g_dly
        logic [PIPE_DELAY-1:0] vis_q;
        logic [PIPE_DELAY-1:0] hsy_q;
        logic [PIPE_DELAY-1:0] vsy_q;

        // Free-running delay line (every clk) so held raster values still drain through.
        always_ff @(posedge clk) begin
            if (rst) begin
                vis_q <= '0;
                hsy_q <= {PIPE_DELAY{~SYNC_POL}};
                vsy_q <= {PIPE_DELAY{~SYNC_POL}};
            end else begin
                vis_q[0] <= vis_raw;
                hsy_q[0] <= hsync_raw;
                vsy_q[0] <= vsync_raw;
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    vis_q[i] <= vis_q[i-1];
                    hsy_q[i] <= hsy_q[i-1];
                    vsy_q[i] <= vsy_q[i-1];
                end
            end
        end

        assign video_on = vis_q[PIPE_DELAY-1];
        assign hsync    = hsy_q[PIPE_DELAY-1];
        assign vsync    = vsy_q[PIPE_DELAY-1];
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl: two small-raster instances (one divided and
// pipelined, one undivided/combinational with positive sync) compared every
// cycle against an arithmetic model of the raster, plus directed sequences.
module tb_vga_timing_ctrl;

    // Instance A: divided clock, 2-stage delay, active-low sync.
    localparam int A_DIV = 3, A_HA = 6, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VA = 4, A_VF = 1, A_VS = 2, A_VB = 2, A_PD = 2;
    localparam logic A_POL = 1'b0;
    // Instance B: pixel every clk, no delay, active-high sync.
    localparam int B_DIV = 1, B_HA = 4, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VA = 3, B_VF = 1, B_VS = 1, B_VB = 1, B_PD = 0;
    localparam logic B_POL = 1'b1;

    typedef struct {
        int div, ha, hf, hs, hb, va, vf, vs, vb, pd, pol;
    } cfg_t;

    typedef struct {
        bit rst;
        bit en;
        int cycles;
        int exp_x;
        int exp_y;
        int exp_fc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [9:0] cx [2];
    logic [9:0] cy [2];
    logic       tick [2];
    logic       vid [2];
    logic       hsy [2];
    logic       vsy [2];
    logic       ls [2];
    logic       fs [2];
    logic [7:0] fc [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model state: enabled clocks since reset, strobes, and raw-flag history.
    int en_clks [2];
    bit m_ls [2];
    bit m_fs [2];
    bit h_vis [2][8];
    bit h_hs  [2][8];
    bit h_vs  [2][8];

    vga_timing_ctrl #(
        .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .SYNC_POL(A_POL), .PIPE_DELAY(A_PD)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable),
        .counter_x(cx[0]), .counter_y(cy[0]), .pix_tick(tick[0]),
        .video_on(vid[0]), .hsync(hsy[0]), .vsync(vsy[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fc[0])
    );

    vga_timing_ctrl #(
        .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .SYNC_POL(B_POL), .PIPE_DELAY(B_PD)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable),
        .counter_x(cx[1]), .counter_y(cy[1]), .pix_tick(tick[1]),
        .video_on(vid[1]), .hsync(hsy[1]), .vsync(vsy[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fc[1])
    );

    always #5 clk = ~clk;

    function automatic cfg_t cfg(input int d);
        cfg_t c;
        if (d == 0) begin
            c.div = A_DIV; c.ha = A_HA; c.hf = A_HF; c.hs = A_HS; c.hb = A_HB;
            c.va = A_VA; c.vf = A_VF; c.vs = A_VS; c.vb = A_VB; c.pd = A_PD; c.pol = int'(A_POL);
        end else begin
            c.div = B_DIV; c.ha = B_HA; c.hf = B_HF; c.hs = B_HS; c.hb = B_HB;
            c.va = B_VA; c.vf = B_VF; c.vs = B_VS; c.vb = B_VB; c.pd = B_PD; c.pol = int'(B_POL);
        end
        return c;
    endfunction

    function automatic int htot(input cfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.va + c.vf + c.vs + c.vb;
    endfunction

    // Position implied by the number of pixels elapsed since reset.
    function automatic int mx(input int d);
        cfg_t c = cfg(d);
        return (en_clks[d] / c.div) % htot(c);
    endfunction

    function automatic int my(input int d);
        cfg_t c = cfg(d);
        return (en_clks[d] / c.div / htot(c)) % vtot(c);
    endfunction

    function automatic int mfc(input int d);
        cfg_t c = cfg(d);
        return (en_clks[d] / c.div / (htot(c) * vtot(c))) % 256;
    endfunction

    function automatic void raw_flags(input int d, input int x, input int y,
                                      output bit v, output bit h, output bit s);
        cfg_t c = cfg(d);
        v = (x < c.ha) && (y < c.va);
        h = (x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hs);
        s = (y >= c.va + c.vf) && (y < c.va + c.vf + c.vs);
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            en_clks[d] = 0;
            m_ls[d] = 1'b0;
            m_fs[d] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_vis[d][i] = 1'b0;
                h_hs[d][i]  = 1'b0;
                h_vs[d][i]  = 1'b0;
            end
        end
    endtask

    task automatic model_step(input bit r, input bit e);
        if (r) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                cfg_t c = cfg(d);
                bit v, h, s, tk;
                tk = e && (en_clks[d] % c.div == c.div - 1);
                raw_flags(d, mx(d), my(d), v, h, s);
                for (int i = 7; i > 0; i--) begin
                    h_vis[d][i] = h_vis[d][i-1];
                    h_hs[d][i]  = h_hs[d][i-1];
                    h_vs[d][i]  = h_vs[d][i-1];
                end
                h_vis[d][0] = v;
                h_hs[d][0]  = h;
                h_vs[d][0]  = s;
                if (e) en_clks[d]++;
                m_ls[d] = tk && (mx(d) == 0);
                m_fs[d] = m_ls[d] && (my(d) == 0);
            end
        end
    endtask

    task automatic check_model(input bit e);
        for (int d = 0; d < 2; d++) begin
            cfg_t c = cfg(d);
            bit v, h, s;
            if (c.pd == 0) begin
                raw_flags(d, mx(d), my(d), v, h, s);
            end else begin
                v = h_vis[d][c.pd-1];
                h = h_hs[d][c.pd-1];
                s = h_vs[d][c.pd-1];
            end
            chk("pix_tick", d, int'(tick[d]), int'(e && (en_clks[d] % c.div == c.div - 1)));
            chk("counter_x", d, int'(cx[d]), mx(d));
            chk("counter_y", d, int'(cy[d]), my(d));
            chk("frame_count", d, int'(fc[d]), mfc(d));
            chk("line_start", d, int'(ls[d]), int'(m_ls[d]));
            chk("frame_start", d, int'(fs[d]), int'(m_fs[d]));
            chk("video_on", d, int'(vid[d]), int'(v));
            chk("hsync", d, int'(hsy[d]), h ? c.pol : 1 - c.pol);
            chk("vsync", d, int'(vsy[d]), s ? c.pol : 1 - c.pol);
        end
    endtask

    // One clk: drive inputs after the falling edge, check, then advance model on the rising edge.
    task automatic cycle(input bit r, input bit e);
        rst = r;
        enable = e;
        #1;
        check_model(e);
        @(posedge clk);
        model_step(r, e);
        @(negedge clk);
    endtask

    initial begin
        vec_t vt [6];
        int k, nfs_a, nls_a, nfs_b;
        bit done_hs;

        vt[0] = '{rst: 1'b1, en: 1'b0, cycles: 2,   exp_x: 0,  exp_y: 0, exp_fc: 0};
        vt[1] = '{rst: 1'b0, en: 1'b1, cycles: 30,  exp_x: 10, exp_y: 0, exp_fc: 0};
        vt[2] = '{rst: 1'b0, en: 1'b0, cycles: 7,   exp_x: 10, exp_y: 0, exp_fc: 0};
        vt[3] = '{rst: 1'b0, en: 1'b1, cycles: 39,  exp_x: 10, exp_y: 1, exp_fc: 0};
        vt[4] = '{rst: 1'b0, en: 1'b1, cycles: 351, exp_x: 10, exp_y: 1, exp_fc: 1};
        vt[5] = '{rst: 1'b1, en: 1'b1, cycles: 1,   exp_x: 0,  exp_y: 0, exp_fc: 0};

        // Bring both instances out of an unknown power-up state before checking.
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Table-driven phases with hand-computed end positions for instance A.
        for (int i = 0; i < 6; i++) begin
            for (int n = 0; n < vt[i].cycles; n++) cycle(vt[i].rst, vt[i].en);
            chk("vec_x", 0, int'(cx[0]), vt[i].exp_x);
            chk("vec_y", 0, int'(cy[0]), vt[i].exp_y);
            chk("vec_fc", 0, int'(fc[0]), vt[i].exp_fc);
        end

        // Hold the raster at x=5 for 50 clk, then resume within CLK_DIV clk.
        k = 0;
        while (int'(cx[0]) != 5 && k < 60) begin
            cycle(1'b0, 1'b1);
            k++;
        end
        chk("reach_x5", 0, int'(cx[0]), 5);
        repeat (50) cycle(1'b0, 1'b0);
        chk("hold_x", 0, int'(cx[0]), 5);
        chk("hold_tick", 0, int'(tick[0]), 0);
        k = 0;
        while (int'(cx[0]) != 6 && k < A_DIV) begin
            cycle(1'b0, 1'b1);
            k++;
        end
        chk("resume_x", 0, int'(cx[0]), 6);

        // Mid-frame reset at y=5.
        k = 0;
        while (int'(cy[0]) != 5 && k < 500) begin
            cycle(1'b0, 1'b1);
            k++;
        end
        chk("reach_y5", 0, int'(cy[0]), 5);
        cycle(1'b1, 1'b1);
        chk("rst_x", 0, int'(cx[0]), 0);
        chk("rst_y", 0, int'(cy[0]), 0);
        chk("rst_hsync", 0, int'(hsy[0]), 1);
        chk("rst_vsync", 0, int'(vsy[0]), 1);
        chk("rst_video", 0, int'(vid[0]), 0);
        chk("rst_fc", 0, int'(fc[0]), 0);
        chk("rst_fs", 0, int'(fs[0]), 0);

        // Long run: strobe counts for A, 256-frame wrap for B.
        nfs_a = 0; nls_a = 0; nfs_b = 0; done_hs = 1'b0;
        for (int n = 1; n <= 12288; n++) begin
            cycle(1'b0, 1'b1);
            if (n <= 1053) begin
                nfs_a += int'(fs[0]);
                nls_a += int'(ls[0]);
                if (fs[0]) begin
                    chk("fs_at_origin_x", 0, int'(cx[0]), 0);
                    chk("fs_at_origin_y", 0, int'(cy[0]), 0);
                end
            end
            nfs_b += int'(fs[1]);
            if (!done_hs && int'(cx[1]) == B_HA + B_HF) begin
                chk("hsync_same_clk", 1, int'(hsy[1]), 1);
                done_hs = 1'b1;
            end
            if (n == 1053) begin
                chk("frames3_count", 0, nfs_a, 3);
                chk("lines_3frames", 0, nls_a, 27);
                chk("frames3_fc", 0, int'(fc[0]), 3);
            end
            if (n == 12240) chk("fc_255", 1, int'(fc[1]), 255);
        end
        chk("hsync_seen", 1, int'(done_hs), 1);
        chk("fc_wrap", 1, int'(fc[1]), 0);
        chk("fs_256", 1, nfs_b, 256);

        // Randomised enable with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
